booth_mac_accumulator: RTL and testbench

Downstream consumer and sequencer for the radix-4 Booth multiplier core. It re-arms the core for each product through the core's active-low reset, waits for the core's sticky done flag, and captures the 2N-bit signed product. Each product is added into a saturating ACC_W-bit accumulator. After LEN products it presents the sum on a valid/ready result port. Together they form a multiply-accumulate datapath for dot-product jobs.

---
 rtl/booth_mac_accumulator_pkg.sv | 31 +++
 rtl/booth_mac_accumulator_if.sv | 29 ++
 rtl/booth_mac_accumulator_sat_adder.sv | 39 +++
 rtl/booth_mac_accumulator.sv | 138 +++++++++++++
 tb/tb_booth_mac_accumulator.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_mac_accumulator_pkg.sv
// Shared constants for the Booth MAC accumulator: FSM state codes,
// saturation bounds at the default accumulator width, and job-length decoding.
package booth_mac_accumulator_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_ARM    = 3'd1;
    localparam state_t S_GUARD  = 3'd2;
    localparam state_t S_WAIT   = 3'd3;
    localparam state_t S_SETTLE = 3'd4;
    localparam state_t S_ACC    = 3'd5;
    localparam state_t S_DONE   = 3'd6;

    localparam int ACC_W_DEF = 40;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX =
        {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN =
        {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // A len of 0 encodes 256 products, so counts need one extra bit.
    localparam int CNT_W = 9;

    function automatic logic [CNT_W-1:0] len_decode(
        input logic [7:0] l
    );
        return (l == 8'd0) ? CNT_W'(256) : CNT_W'(l);
    endfunction

endpackage

// File: rtl/booth_mac_accumulator_if.sv
// Result port bundle: valid/ready handshake carrying sum and status flags.
// master drives res_valid/res_data/res_sat/res_err; slave drives res_ready.
interface booth_mac_accumulator_if
    import booth_mac_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_sat;
    logic             res_err;

    modport master (
        output res_valid,
        output res_data,
        output res_sat,
        output res_err,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_sat,
        input  res_err,
        output res_ready
    );
endinterface

// File: rtl/booth_mac_accumulator_sat_adder.sv
// Combinational signed add of a sign-extended B_W operand into an A_W value,
// clamping to the signed range. Ports: i_a, i_b in; o_sum, o_sat out.
module sat_adder
    import booth_mac_accumulator_pkg::*;
#(
    parameter int A_W = ACC_W_DEF,
    parameter int B_W = 32
) (
    input  logic [A_W-1:0] i_a,
    input  logic [B_W-1:0] i_b,
    output logic [A_W-1:0] o_sum,
    output logic           o_sat
);
    localparam logic [A_W-1:0] L_MAX = {1'b0, {(A_W-1){1'b1}}};
    localparam logic [A_W-1:0] L_MIN = {1'b1, {(A_W-1){1'b0}}};

    logic [A_W-1:0] w_b_ext;
    logic [A_W-1:0] w_raw;
    logic           w_pos;
    logic           w_neg;

    assign w_b_ext = {{(A_W-B_W){i_b[B_W-1]}}, i_b};
    assign w_raw   = i_a + w_b_ext;

    // Overflow only when both operands share a sign the result lacks.
    assign w_pos = ~i_a[A_W-1] & ~w_b_ext[A_W-1] & w_raw[A_W-1];
    assign w_neg = i_a[A_W-1] & w_b_ext[A_W-1] & ~w_raw[A_W-1];

    always_comb begin
        o_sum = w_raw;
        unique case (1'b1)
            w_pos:   o_sum = L_MAX;
            w_neg:   o_sum = L_MIN;
            default: o_sum = w_raw;
        endcase
    end

    assign o_sat = w_pos | w_neg;
endmodule

// File: rtl/booth_mac_accumulator.sv
// Sequences the Booth core per product (reset pulse, wait done, capture) and
// accumulates with saturation. Ports: clk, reset (sync, active-low), i_start,
// i_len, i_prod_in, i_prod_done, o_core_rst_n, o_op_req, o_busy, res (master).
module booth_mac_accumulator
    import booth_mac_accumulator_pkg::*;
#(
    parameter int N       = 16,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_start,
    input  logic [7:0]     i_len,
    input  logic [2*N-1:0] i_prod_in,
    input  logic           i_prod_done,
    output logic           o_core_rst_n,
    output logic           o_op_req,
    output logic           o_busy,
    booth_mac_accumulator_if.master res
);
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_end;
    logic [2*N-1:0]   r_prod_q;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;
    logic             r_sat;
    logic             r_err;
    logic             r_core_rst_n;
    logic             w_busy;
    logic             w_valid;
    logic             w_crn_nxt;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_tmo_end = (r_tmo == TMO_W'(TIMEOUT-1));

    sat_adder #(
        .A_W (ACC_W),
        .B_W (2*N)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (r_prod_q),
        .o_sum (w_sum),
        .o_sat (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (i_start) w_next = S_ARM;
            S_ARM:    w_next = S_GUARD;
            S_GUARD:  w_next = S_WAIT;
            S_WAIT: begin
                if (i_prod_done) w_next = S_SETTLE;
                else if (w_tmo_end) w_next = S_DONE;
            end
            S_SETTLE: w_next = S_ACC;
            S_ACC: begin
                if (w_cnt_inc == r_len) w_next = S_DONE;
                else w_next = S_ARM;
            end
            S_DONE:   if (res.res_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Core reset is registered from the next state so it is glitch-free
    // and exactly one cycle long, aligned with ARM.
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_valid   = (r_state == S_DONE);
        w_crn_nxt = (w_next != S_ARM);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len        <= '0;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_prod_q     <= '0;
            r_acc        <= '0;
            r_sat        <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_core_rst_n <= w_crn_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len <= len_decode(i_len);
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_sat <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                S_GUARD: r_tmo <= '0;
                S_WAIT: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (!i_prod_done && w_tmo_end) begin
                        r_err <= 1'b1;
                    end
                end
                S_SETTLE: r_prod_q <= i_prod_in;
                S_ACC: begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_inc;
                    if (w_ovf) r_sat <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_core_rst_n  = r_core_rst_n;
    assign o_op_req      = ~r_core_rst_n;
    assign o_busy        = w_busy;
    assign res.res_valid = w_valid;
    assign res.res_data  = r_acc;
    assign res.res_sat   = r_sat;
    assign res.res_err   = r_err;
endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Bench for booth_mac_accumulator: a 40-bit and a 33-bit instance share one
// behavioural Booth-core model; results are checked against an integer model.
module tb_booth_mac_accumulator;
    import booth_mac_accumulator_pkg::*;

    localparam int AW  = 40;
    localparam int NW  = 33;
    localparam int TMO = 64;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len   = 8'd0;
    logic        rdy   = 1'b0;
    logic [31:0] prod_in;
    logic        prod_done;
    logic        core_rst_n, op_req, busy;
    logic        core_rst_n2, op_req2, busy2;

    booth_mac_accumulator_if #(.ACC_W(AW)) rif ();
    booth_mac_accumulator_if #(.ACC_W(NW)) rif2 ();

    assign rif.res_ready  = rdy;
    assign rif2.res_ready = rdy;

    always #5 clk = ~clk;

    booth_mac_accumulator #(.N(16), .ACC_W(AW), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start),
        .i_len        (len),
        .i_prod_in    (prod_in),
        .i_prod_done  (prod_done),
        .o_core_rst_n (core_rst_n),
        .o_op_req     (op_req),
        .o_busy       (busy),
        .res          (rif)
    );

    booth_mac_accumulator #(.N(16), .ACC_W(NW), .TIMEOUT(TMO)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start),
        .i_len        (len),
        .i_prod_in    (prod_in),
        .i_prod_done  (prod_done),
        .o_core_rst_n (core_rst_n2),
        .o_op_req     (op_req2),
        .o_busy       (busy2),
        .res          (rif2)
    );

    // Booth core model: product k of the job appears after d_tab[k]
    // enabled cycles; delay 0 means the core never finishes.
    int          p_tab [8];
    int          d_tab [8];
    int          p_n      = 1;
    int          pulses   = 0;
    int          job_base = 0;
    int          c_cnt    = 0;
    int          c_dly    = 0;
    int          k;
    logic [31:0] m_prod   = 32'd0;
    logic        m_done   = 1'b0;

    assign prod_in   = m_prod;
    assign prod_done = m_done;

    always @(posedge clk) begin
        if (!core_rst_n) begin
            k = (pulses - job_base) % p_n;
            m_prod <= p_tab[k];
            c_dly  <= d_tab[k];
            c_cnt  <= 0;
            m_done <= 1'b0;
            pulses <= pulses + 1;
        end else begin
            c_cnt <= c_cnt + 1;
            if (c_dly != 0 && c_cnt + 1 >= c_dly) m_done <= 1'b1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] e_data;
    bit            e_sat, e_err, e_hold;
    logic [NW-1:0] n_data;
    bit            n_sat;
    int            e_pulses;
    logic          prev_crn = 1'b0;
    logic [AW-1:0] g_data;
    bit            g_sat, g_err;
    logic [NW-1:0] h_data;
    bit            h_sat;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Expected job outcome from plain saturating integer arithmetic.
    task automatic model(input int len_in);
        longint s1, s2, mx1, mn1, mx2, mn2;
        int cnt;
        mx1 = longint'(ACC_MAX);
        mn1 = -mx1 - 1;
        mx2 = (longint'(1) <<< (NW-1)) - 1;
        mn2 = -mx2 - 1;
        s1 = 0;
        s2 = 0;
        cnt = (len_in == 0) ? 256 : len_in;
        e_sat = 0;
        n_sat = 0;
        e_err = 0;
        e_pulses = cnt;
        for (int i = 0; i < cnt; i++) begin
            if (d_tab[i % p_n] == 0) begin
                e_err = 1;
                e_pulses = i + 1;
                break;
            end
            s1 += p_tab[i % p_n];
            s2 += p_tab[i % p_n];
            if (s1 > mx1) begin s1 = mx1; e_sat = 1; end
            if (s1 < mn1) begin s1 = mn1; e_sat = 1; end
            if (s2 > mx2) begin s2 = mx2; n_sat = 1; end
            if (s2 < mn2) begin s2 = mn2; n_sat = 1; end
        end
        e_data = s1[AW-1:0];
        n_data = s2[NW-1:0];
    endtask

    // One clock, then the per-cycle comparison against the model.
    task automatic step();
        @(posedge clk);
        #1;
        if (reset) begin
            chk("op_req", op_req, !core_rst_n);
            chk("op_req2", op_req2, !core_rst_n2);
            if (rif.res_valid || (!busy && e_hold)) begin
                chk("res_data", rif.res_data, e_data);
                chk("res_sat", rif.res_sat, e_sat);
                chk("res_err", rif.res_err, e_err);
            end
            if (rif.res_valid) chk("busy_in_done", busy, 1);
            if (busy && !prev_crn) chk("crn_one_cycle", core_rst_n, 1);
        end
        prev_crn = core_rst_n;
    endtask

    task automatic run_job(input int len_in, input int wait_rdy,
                           input bit poke, input int exp_lat);
        int lat;
        model(len_in);
        job_base = pulses;
        e_hold = 0;
        len = len_in[7:0];
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        while (!rif.res_valid && lat < 3000) begin
            step();
            lat++;
        end
        chk("res_valid_seen", rif.res_valid, 1);
        chk("res_valid2_seen", rif2.res_valid, 1);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        chk("core_pulses", pulses - job_base, e_pulses);
        chk("n_data", rif2.res_data, n_data);
        chk("n_sat", rif2.res_sat, n_sat);
        chk("n_err", rif2.res_err, e_err);
        g_data = rif.res_data;
        g_sat  = rif.res_sat;
        g_err  = rif.res_err;
        h_data = rif2.res_data;
        h_sat  = rif2.res_sat;
        for (int i = 0; i < wait_rdy; i++) begin
            if (poke && i == 3) start = 1'b1;
            step();
            start = 1'b0;
            chk("hold_valid", rif.res_valid, 1);
        end
        rdy = 1'b1;
        e_hold = 1;
        step();
        rdy = 1'b0;
        chk("valid_drop", rif.res_valid, 0);
        chk("idle_after", busy, 0);
        step();
        chk("start_ignored", busy, 0);
    endtask

    initial begin
        e_data = '0;
        n_data = '0;
        e_hold = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rif.res_valid, 0);
        chk("rst_crn", core_rst_n, 0);
        chk("rst_op_req", op_req, 1);
        chk("rst_data", rif.res_data, 0);
        chk("rst_sat", rif.res_sat, 0);
        chk("rst_err", rif.res_err, 0);
        reset = 1'b1;
        e_sat = 0;
        e_err = 0;
        e_hold = 1;
        step();
        chk("idle_crn", core_rst_n, 1);
        step();

        // single product
        p_tab[0] = 32'h0000_0C00; d_tab[0] = 9; p_n = 1;
        run_job(1, 0, 0, -1);
        chk("single_data", g_data, 40'h00_0000_0C00);
        chk("single_sat", g_sat, 0);
        chk("single_err", g_err, 0);

        // signed accumulate with backpressure and ignored start
        p_tab[0] = 1000; p_tab[1] = -3000; p_tab[2] = 500;
        d_tab[0] = 3; d_tab[1] = 1; d_tab[2] = 5; p_n = 3;
        run_job(3, 10, 1, -1);
        chk("signed_data", g_data, 40'hFF_FFFF_FA24);
        chk("signed_n", h_data, 33'h1_FFFF_FA24);

        // clamp then keep accumulating in the narrow instance
        p_tab[0] = 32'h7FFF_FFFF; p_tab[1] = 32'h7FFF_FFFF;
        p_tab[2] = 32'h7FFF_FFFF; p_tab[3] = -5;
        d_tab[0] = 2; d_tab[1] = 2; d_tab[2] = 2; d_tab[3] = 4;
        p_n = 4;
        run_job(4, 0, 0, -1);
        chk("mix_data", g_data, 40'h01_7FFF_FFF8);
        chk("mix_sat", g_sat, 0);
        chk("mix_n_data", h_data, 33'h0_FFFF_FFFA);
        chk("mix_n_sat", h_sat, 1);

        // len=0 means 256 positive maxima
        p_tab[0] = 32'h7FFF_FFFF; d_tab[0] = 1; p_n = 1;
        run_job(0, 0, 0, -1);
        chk("pos256_data", g_data, 40'h7F_FFFF_FF00);
        chk("pos256_sat", g_sat, 0);
        chk("pos256_n", h_data, 33'h0_FFFF_FFFF);
        chk("pos256_n_sat", h_sat, 1);

        // 256 negative minima land exactly on the floor
        p_tab[0] = 32'h8000_0000; d_tab[0] = 1; p_n = 1;
        run_job(0, 0, 0, -1);
        chk("neg256_data", g_data, ACC_MIN);
        chk("neg256_sat", g_sat, 0);
        chk("neg256_n", h_data, 33'h1_0000_0000);
        chk("neg256_n_sat", h_sat, 1);

        // core never finishes
        p_tab[0] = 123; d_tab[0] = 0; p_n = 1;
        run_job(1, 0, 0, 2 + TMO);
        chk("tmo_err", g_err, 1);
        chk("tmo_data", g_data, 40'd0);

        // timeout on the second product keeps the partial sum
        p_tab[0] = 100; p_tab[1] = 200; p_tab[2] = 300;
        d_tab[0] = 2; d_tab[1] = 0; d_tab[2] = 2; p_n = 3;
        run_job(3, 0, 0, -1);
        chk("ptmo_err", g_err, 1);
        chk("ptmo_data", g_data, 40'd100);

        // reset while waiting on the second product
        p_tab[0] = 7; p_tab[1] = 9; d_tab[0] = 1; d_tab[1] = 40;
        p_n = 2;
        e_hold = 0;
        job_base = pulses;
        len = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        chk("mid_busy", busy, 1);
        chk("mid_acc", rif.res_data, 40'd7);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", rif.res_valid, 0);
        chk("mid_rst_crn", core_rst_n, 0);
        chk("mid_rst_data", rif.res_data, 0);
        chk("mid_rst_sat", rif.res_sat, 0);
        reset = 1'b1;
        e_data = '0;
        e_sat = 0;
        e_err = 0;
        e_hold = 1;
        step();
        chk("mid_rst_idle", busy, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
